npc_pred: RTL

NPC_PRED -- requirements
Module: npc_pred

---
 rtl/npc_pred.sv | 132 +++++++++++++
 1 files changed

// File: rtl/npc_pred.sv
// Next-PC predictor: direct-mapped BTB with 2-bit counters, looked up on the
// fetch PC, trained and checked for mispredicts by the resolved EX instruction.
module npc_pred #(
   parameter int              XLEN      = 32,
   parameter int              BTB_DEPTH = 16,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic            ex_is_br_i,
   input  logic            ex_is_jal_i,
   input  logic            ex_is_jalr_i,
   input  logic            ex_taken_i,
   input  logic [XLEN-1:0] ex_target_i,
   input  logic            ex_pred_taken_i,
   input  logic [XLEN-1:0] ex_pred_target_i,
   output logic            flush_o
);

   localparam int              IDX_W = $clog2(BTB_DEPTH);
   localparam int              TAG_W = XLEN - IDX_W - 2;
   localparam logic [XLEN-1:0] FOUR  = XLEN'(4);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             valid_q  [BTB_DEPTH];
   logic             valid_d  [BTB_DEPTH];
   logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
   logic [TAG_W-1:0] tag_d    [BTB_DEPTH];
   logic [XLEN-1:0]  target_q [BTB_DEPTH];
   logic [XLEN-1:0]  target_d [BTB_DEPTH];
   logic             jump_q   [BTB_DEPTH];
   logic             jump_d   [BTB_DEPTH];
   logic [1:0]       cnt_q    [BTB_DEPTH];
   logic [1:0]       cnt_d    [BTB_DEPTH];

   logic [IDX_W-1:0] f_idx, ex_idx;
   logic [TAG_W-1:0] f_tag, ex_tag;
   logic             f_hit, ex_hit, ex_is_jump, ex_act_taken;
   logic [XLEN-1:0]  act_target, ex_seq, actual_next, predicted_next;

   // Fetch-side lookup
   assign f_idx         = pc_q[IDX_W+1:2];
   assign f_tag         = pc_q[XLEN-1:IDX_W+2];
   assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_taken_o  = f_hit && (jump_q[f_idx] || cnt_q[f_idx][1]);
   assign pred_target_o = pred_taken_o ? target_q[f_idx] : pc_q + FOUR;
   assign pc_o          = pc_q;

   // EX-side resolution
   assign ex_idx         = ex_pc_i[IDX_W+1:2];
   assign ex_tag         = ex_pc_i[XLEN-1:IDX_W+2];
   assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_is_jump     = ex_is_jal_i || ex_is_jalr_i;
   assign ex_act_taken   = ex_is_jump || (ex_is_br_i && ex_taken_i);
   assign act_target     = ex_is_jalr_i ? {ex_target_i[XLEN-1:1], 1'b0} : ex_target_i;
   assign ex_seq         = ex_pc_i + FOUR;
   assign actual_next    = ex_act_taken ? act_target : ex_seq;
   assign predicted_next = ex_pred_taken_i ? ex_pred_target_i : ex_seq;
   assign flush_o        = ex_valid_i && (actual_next != predicted_next);

   always_comb begin
      pc_d = pred_target_o;
      if (flush_o) begin
         pc_d = actual_next;
      end else if (stall_i) begin
         pc_d = pc_q;
      end
   end

   // Training; only the entry selected by the EX PC can change
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      jump_d   = jump_q;
      cnt_d    = cnt_q;
      if (ex_valid_i) begin
         if (ex_is_jump) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = act_target;
            jump_d[ex_idx]   = 1'b1;
            cnt_d[ex_idx]    = 2'b11;
         end else if (ex_is_br_i) begin
            if (ex_hit) begin
               if (ex_taken_i) begin
                  target_d[ex_idx] = act_target;
                  if (cnt_q[ex_idx] != 2'b11) cnt_d[ex_idx] = cnt_q[ex_idx] + 2'b01;
               end else if (cnt_q[ex_idx] != 2'b00) begin
                  cnt_d[ex_idx] = cnt_q[ex_idx] - 2'b01;
               end
            end else if (ex_taken_i) begin
               valid_d[ex_idx]  = 1'b1;
               tag_d[ex_idx]    = ex_tag;
               target_d[ex_idx] = act_target;
               jump_d[ex_idx]   = 1'b0;
               cnt_d[ex_idx]    = 2'b10;
            end
         end else if (ex_pred_taken_i && ex_hit) begin
            // A non-control instruction was predicted taken: drop the stale entry
            valid_d[ex_idx] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            jump_q[i]   <= 1'b0;
            cnt_q[i]    <= 2'b00;
         end
      end else begin
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         jump_q   <= jump_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
